// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side request and EX-side forwarding/stall response bundle
// for fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_memread;
   logic              ex_flush;
   logic              pipe_hold;
   logic              stall;
   logic              bubble;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2,
      output id_uses_rs1, id_uses_rs2,
      output id_rd, id_regwrite, id_memread,
      output ex_flush, pipe_hold,
      input  stall, bubble,
      input  fwd_a_sel, fwd_b_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2,
      input  id_uses_rs1, id_uses_rs2,
      input  id_rd, id_regwrite, id_memread,
      input  ex_flush, pipe_hold,
      output stall, bubble,
      output fwd_a_sel, fwd_b_sel, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller with EX/MEM/WB destination shadow.
// FWD_HAZARD_FORWARDING_EN enables operand forwarding; otherwise stall to WB.
module fwd_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   fwd_hazard_ctrl_if.slave bus
);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
   } shd_t;

   shd_t              ex_q;
   shd_t              mem_q;
   shd_t              wb_q;
   shd_t              id_s;
   logic [REG_AW-1:0] ex_rs1_q;
   logic [REG_AW-1:0] ex_rs2_q;
   logic              ex_u1_q;
   logic              ex_u2_q;
   logic [1:0]        fwd_a_q;
   logic [1:0]        fwd_b_q;
   logic [1:0]        fwd_a_nx;
   logic [1:0]        fwd_b_nx;
   logic [CNT_W-1:0]  cnt_q;

   logic ex_wr;
   logic mem_wr;
   logic wb_wr;
   logic a_ex;
   logic b_ex;
   logic a_mem;
   logic b_mem;
   logic a_wb;
   logic b_wb;
   logic hazard;
   logic stall;
   logic bubble;
   logic enter;
   logic unused;

   assign ex_wr  = ex_q.v && ex_q.rw && (ex_q.rd != '0);
   assign mem_wr = mem_q.v && mem_q.rw && (mem_q.rd != '0);
   assign wb_wr  = wb_q.v && wb_q.rw && (wb_q.rd != '0);

   assign a_ex  = bus.id_uses_rs1 && (bus.id_rs1 == ex_q.rd);
   assign b_ex  = bus.id_uses_rs2 && (bus.id_rs2 == ex_q.rd);
   assign a_mem = bus.id_uses_rs1 && (bus.id_rs1 == mem_q.rd);
   assign b_mem = bus.id_uses_rs2 && (bus.id_rs2 == mem_q.rd);
   assign a_wb  = bus.id_uses_rs1 && (bus.id_rs1 == wb_q.rd);
   assign b_wb  = bus.id_uses_rs2 && (bus.id_rs2 == wb_q.rd);

`ifdef FWD_HAZARD_FORWARDING_EN
   // Only a load still in EX cannot be bypassed in time.
   assign hazard = bus.id_valid && ex_wr && ex_q.mr
                && (a_ex || b_ex);
   assign unused = ^{a_wb, b_wb, wb_wr, wb_q.mr, mem_q.mr,
                     ex_rs1_q, ex_rs2_q, ex_u1_q, ex_u2_q};
`else
   // Register file commits at end of WB, so any in-flight writer blocks.
   assign hazard = bus.id_valid
                && ((ex_wr && (a_ex || b_ex))
                 || (mem_wr && (a_mem || b_mem))
                 || (wb_wr && (a_wb || b_wb)));
   assign unused = ^{wb_q.mr, mem_q.mr, ex_q.mr,
                     ex_rs1_q, ex_rs2_q, ex_u1_q, ex_u2_q};
`endif

   assign stall  = hazard && !bus.ex_flush;
   assign bubble = stall || bus.ex_flush;
   assign enter  = bus.id_valid && !bubble;

   assign id_s = '{v:  1'b1,
                   rd: bus.id_rd,
                   rw: bus.id_regwrite,
                   mr: bus.id_memread};

   always_comb begin
      fwd_a_nx = 2'b00;
      fwd_b_nx = 2'b00;
`ifdef FWD_HAZARD_FORWARDING_EN
      if (enter) begin
         priority case (1'b1)
            ex_wr && !ex_q.mr && a_ex: fwd_a_nx = 2'b10;
            mem_wr && a_mem:           fwd_a_nx = 2'b01;
            default:                   fwd_a_nx = 2'b00;
         endcase
         priority case (1'b1)
            ex_wr && !ex_q.mr && b_ex: fwd_b_nx = 2'b10;
            mem_wr && b_mem:           fwd_b_nx = 2'b01;
            default:                   fwd_b_nx = 2'b00;
         endcase
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
         ex_u1_q  <= 1'b0;
         ex_u2_q  <= 1'b0;
         fwd_a_q  <= 2'b00;
         fwd_b_q  <= 2'b00;
         cnt_q    <= '0;
      end else if (!bus.pipe_hold) begin
         wb_q     <= mem_q;
         mem_q    <= ex_q;
         ex_q     <= enter ? id_s : '0;
         ex_rs1_q <= bus.id_rs1;
         ex_rs2_q <= bus.id_rs2;
         ex_u1_q  <= enter && bus.id_uses_rs1;
         ex_u2_q  <= enter && bus.id_uses_rs2;
         fwd_a_q  <= fwd_a_nx;
         fwd_b_q  <= fwd_b_nx;
         if (stall && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.stall     = stall;
   assign bus.bubble    = bubble;
   assign bus.fwd_a_sel = fwd_a_q;
   assign bus.fwd_b_sel = fwd_b_q;
   assign bus.stall_cnt = cnt_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

- Forwarding and hazard controller for the 5-stage integer pipeline.
- Keeps a shadow copy of the destination-register state for the EX, MEM and WB stages.
- Produces registered 2-bit select codes for the two EX-stage operand forwarding muxes, plus load-use/RAW stall and bubble requests to the fetch/decode registers.
- Sits beside the ID/EX pipeline register and drives both EX operand muxes directly.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source registers of the ID instruction
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  REG_AW  destination of the ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- ex_flush  in  1  branch/jump taken in EX; squash ID
- pipe_hold  in  1  memory wait; whole pipeline frozen
- stall  out  1  freeze PC and IF/ID (combinational)
- bubble  out  1  load NOP into ID/EX (combinational)
- fwd_a_sel, fwd_b_sel  out  2  operand select for the EX instruction: 00 register file, 01 WB result, 10 MEM ALU result; 11 never driven
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow stages EX, MEM and WB each hold: valid, rd, regwrite, memread. EX additionally holds rs1, rs2 and their use flags.
- A stage is a "writer" iff valid && regwrite && rd != 0.
- Advance occurs on each rising edge with pipe_hold=0:
  - WB <= MEM
  - MEM <= EX
  - EX <= bubble ? invalid : (id_valid ? ID fields : invalid)
- With pipe_hold=1, all state and fwd selects hold; stall_cnt holds.
- Load-use hazard: EX is a writer && ex.memread && id_valid && ((id_uses_rs1 && id_rs1==ex.rd) || (id_uses_rs2 && id_rs2==ex.rd)).
- stall = hazard && !ex_flush.
- bubble = stall || ex_flush. A flush has priority because the ID instruction is on the wrong path.
- Next fwd_a_sel, computed at advance for the instruction entering EX, with priority high to low:
  - 10 if the current EX is a writer, is not a load, and its rd == id_rs1 (it becomes MEM)
  - else 01 if the current MEM is a writer and its rd == id_rs1 (it becomes WB)
  - else 00
- fwd_b_sel is computed identically using id_rs2.
- When a bubble or an invalid instruction enters EX, both selects load 00. A source with its use flag cleared also gets 00.
- Load data is forwarded only from WB (code 01), never from MEM.

## Timing
- Reset (asynchronous): all shadow valids 0, fwd_a_sel=fwd_b_sel=00, stall_cnt=0, stall=0, bubble=0.
- fwd selects are registered and valid during the whole cycle the consuming instruction occupies EX.
- A load-use hazard costs exactly 1 stall cycle (forwarding on). After it, the load is in WB when the consumer reaches EX, so the consumer gets sel 01.
- stall/bubble are combinational from registered state and ID inputs; there is no added latency.
- If ex_flush and a hazard occur in the same cycle: stall=0, bubble=1.
- If pipe_hold=1 and a hazard occur in the same cycle: stall still asserts. It is not counted, and state does not advance.
- stall_cnt increments on edges where stall=1 && pipe_hold=0. It saturates at all-ones with no wrap-around.
- rd=0 never forwards and never stalls.

## Configuration
- FWD_HAZARD_FORWARDING_EN defined: behaviour as above.
- FWD_HAZARD_FORWARDING_EN undefined:
  - fwd_a_sel and fwd_b_sel are held at 00.
  - stall asserts while any ID source in use matches a writer rd in EX, MEM or WB, since the register file commits at the end of WB.
  - A dependence on the immediately preceding instruction therefore costs 3 stall cycles.
  - The ex_flush and pipe_hold rules are unchanged.

## Test plan
- Reset asserted mid-stream with EX/MEM/WB valid -> same cycle: selects 00, stall=0, stall_cnt=0. After release with id_valid=0 for 3 cycles, no forwarding.
- add x5 issued, then sub using rs1=x5 -> sub in EX with fwd_a_sel=10. A third instruction using rs2=x5 two slots later -> fwd_b_sel=01.
- lw x7, then add using rs1=x7 -> stall=1 and bubble=1 for exactly 1 cycle, stall_cnt=1. Add then in EX with fwd_a_sel=01.
- lw x7 and a dependent add in ID with ex_flush=1 in the same cycle -> stall=0, bubble=1, stall_cnt unchanged.
- Load-use hazard with pipe_hold=1 for 4 cycles -> stall stays 1, state and stall_cnt frozen. After release: 1 counted stall, then forwarding as normal.
- Macro undefined: addi x3, then add rs1=x3 -> stall=1 for 3 consecutive cycles, stall_cnt=3, selects always 00.
- Writer with rd=x0 followed by a reader of x0 -> no stall, selects 00.
